pe_mac_scheduler: RTL

- Issue controller for the PE accumulate pipeline: ISSUE → MULT → ADD → WB.
- Accepts a job of num_ops accumulate requests, one output-activation address each.
- Issues each request to the datapath, stalls on read-after-write hazards and selects forwarding of the WB result into the issue-stage operand read.
- Tracks in-flight ops in shadow stages and reports job completion after the pipeline drains.

---
 rtl/pe_mac_scheduler_if.sv | 32 +++
 rtl/pe_mac_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pe_mac_scheduler_if.sv
// Handshake bundle between the PE issue scheduler and its job source / datapath.
// The master side drives jobs, requests and WB feedback; the slave side is the scheduler.
interface pe_mac_scheduler_if #(
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 8,
    parameter int STALL_W = 16
);
    logic               start;
    logic [CNT_W-1:0]   num_ops;
    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_ready;
    logic               issue_en;
    logic [ADDR_W-1:0]  issue_addr;
    logic               fwd_en;
    logic               comp_en_wb;
    logic [ADDR_W-1:0]  out_act_addr_wb;
    logic               busy;
    logic               done;
    logic               err;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output start, num_ops, req_valid, req_addr, comp_en_wb, out_act_addr_wb,
        input  req_ready, issue_en, issue_addr, fwd_en, busy, done, err, stall_cnt
    );

    modport slave (
        input  start, num_ops, req_valid, req_addr, comp_en_wb, out_act_addr_wb,
        output req_ready, issue_en, issue_addr, fwd_en, busy, done, err, stall_cnt
    );
endinterface

// File: rtl/pe_mac_scheduler.sv
// Issue controller for the ISSUE -> MULT -> ADD -> WB accumulate pipeline: hazard
// stalls, WB forwarding select, shadow tracking of in-flight ops and job completion.
module pe_mac_scheduler #(
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 8,
    parameter int STALL_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_mac_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_ops_q, num_ops_d;
    logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sh1_v_q, sh1_v_d;
    logic               sh2_v_q, sh2_v_d;
    logic               sh3_v_q, sh3_v_d;
    logic [ADDR_W-1:0]  sh1_a_q, sh1_a_d;
    logic [ADDR_W-1:0]  sh2_a_q, sh2_a_d;
    logic [ADDR_W-1:0]  sh3_a_q, sh3_a_d;

    logic               hazard;
    logic               req_ready;
    logic               issue_en;
    logic               fwd_en;
    logic               last_issue;

    // sh3 is the op in WB this cycle; its result is forwarded rather than stalled on
    always_comb begin
        hazard     = bus.req_valid &&
                     ((sh1_v_q && (sh1_a_q == bus.req_addr)) ||
                      (sh2_v_q && (sh2_a_q == bus.req_addr)));
        req_ready  = (state_q == RUN) && !hazard && (issued_cnt_q < num_ops_q);
        issue_en   = bus.req_valid && req_ready;
        fwd_en     = issue_en && sh3_v_q && (sh3_a_q == bus.req_addr);
        last_issue = issue_en && ((issued_cnt_q + CNT_W'(1)) == num_ops_q);
    end

    always_comb begin
        state_d      = state_q;
        num_ops_d    = num_ops_q;
        issued_cnt_d = issued_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        err_d        = err_q;

        sh1_v_d = issue_en;
        sh1_a_d = bus.req_addr;
        sh2_v_d = sh1_v_q;
        sh2_a_d = sh1_a_q;
        sh3_v_d = sh2_v_q;
        sh3_a_d = sh2_a_q;

        if ((bus.comp_en_wb != sh3_v_q) ||
            (bus.comp_en_wb && (bus.out_act_addr_wb != sh3_a_q))) begin
            err_d = 1'b1;
        end

        if (issue_en) begin
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
        end

        if ((state_q == RUN) && hazard && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_ops != '0) begin
                        state_d      = RUN;
                        num_ops_d    = bus.num_ops;
                        issued_cnt_d = '0;
                        stall_cnt_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            // The last op retires from WB in the same cycle the shadows empty out,
            // so completion keys off the shadow contents after this edge.
            DRAIN: begin
                if (!sh1_v_d && !sh2_v_d && !sh3_v_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            num_ops_q    <= '0;
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sh1_v_q      <= 1'b0;
            sh2_v_q      <= 1'b0;
            sh3_v_q      <= 1'b0;
            sh1_a_q      <= '0;
            sh2_a_q      <= '0;
            sh3_a_q      <= '0;
        end else begin
            state_q      <= state_d;
            num_ops_q    <= num_ops_d;
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sh1_v_q      <= sh1_v_d;
            sh2_v_q      <= sh2_v_d;
            sh3_v_q      <= sh3_v_d;
            sh1_a_q      <= sh1_a_d;
            sh2_a_q      <= sh2_a_d;
            sh3_a_q      <= sh3_a_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.issue_en   = issue_en;
    assign bus.issue_addr = bus.req_addr;
    assign bus.fwd_en     = fwd_en;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule
